// File: rtl/cpu8_pkg.sv
// Shared definitions for the cpu8 core: opcodes, FSM states and the
// active-low seven-segment glyph table (segment order gfedcba).
package cpu8_pkg;

    typedef enum logic [1:0] {
        OpAdd = 2'b00,
        OpLw  = 2'b01,
        OpSw  = 2'b10,
        OpJ   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        StFetch,
        StExec,
        StMem,
        StWb,
        StWait,
        StHalt
    } state_e;

    localparam logic [6:0] HexSeg [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/hex7seg.sv
// Hex nibble to active-low seven-segment decoder.
module hex7seg
    import cpu8_pkg::*;
(
    input  logic [3:0] value_i,
    output logic [6:0] seg_o
);

    assign seg_o = HexSeg[value_i];

endmodule

// File: rtl/cpu8_core.sv
// Multi-cycle 4-register CPU with free-run / single-step control, internal
// data memory, sticky add carry and a two-digit hex display of the last write.
module cpu8_core
    import cpu8_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned IMEM_AW    = 8,
    parameter int unsigned DMEM_DEPTH = 16
) (
    input  logic               clk50,
    input  logic               reset,
    input  logic               run,
    input  logic               step,
    input  logic [7:0]         instruction,
    output logic [IMEM_AW-1:0] read_address,
    output logic [6:0]         seg_hi,
    output logic [6:0]         seg_lo,
    output logic               led,
    output logic               ovf,
    output logic [15:0]        instr_count
);

    localparam int unsigned DmemAw = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

    state_e              state_q, state_d;
    logic [IMEM_AW-1:0]  pc_q, pc_d;
    logic [7:0]          ir_q, ir_d;
    logic [DATA_W-1:0]   rf_q [4];
    logic [DATA_W-1:0]   rf_d [4];
    logic [DATA_W-1:0]   dmem_q [DMEM_DEPTH];
    logic [DATA_W-1:0]   dmem_d [DMEM_DEPTH];
    logic [DATA_W-1:0]   mdr_q, mdr_d;
    logic [7:0]          display_q, display_d;
    logic                ovf_q, ovf_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                step_q;

    op_e                 op;
    logic [1:0]          rs, rt, fn;
    logic [DATA_W:0]     add_res;
    logic [DmemAw-1:0]   dmem_idx;
    logic                step_edge;
    state_e              next_st;

    // Control strobes from the output decoder
    logic ir_load, rf_we_add, rf_we_lw, mem_rd, mem_wr, pc_inc, pc_jump, retire;

    assign op        = op_e'(ir_q[7:6]);
    assign rs        = ir_q[5:4];
    assign rt        = ir_q[3:2];
    assign fn        = ir_q[1:0];
    assign add_res   = {1'b0, rf_q[rs]} + {1'b0, rf_q[rt]};
    assign dmem_idx  = rf_q[rs][DmemAw-1:0] + DmemAw'(fn);
    assign step_edge = step & ~step_q;
    assign next_st   = run ? StFetch : StWait;

    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch: state_d = StExec;
            StExec: begin
                unique case (op)
                    OpAdd:      state_d = next_st;
                    OpLw, OpSw: state_d = StMem;
                    OpJ:        state_d = (fn == 2'b00) ? StHalt : next_st;
                endcase
            end
            StMem:   state_d = (op == OpLw) ? StWb : next_st;
            StWb:    state_d = next_st;
            // Edges seen outside WAIT are simply never looked at, so they are dropped
            StWait:  state_d = (run || step_edge) ? StFetch : StWait;
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    always_comb begin
        ir_load   = (state_q == StFetch);
        rf_we_add = (state_q == StExec) && (op == OpAdd);
        pc_jump   = (state_q == StExec) && (op == OpJ) && (fn != 2'b00);
        mem_rd    = (state_q == StMem) && (op == OpLw);
        mem_wr    = (state_q == StMem) && (op == OpSw);
        rf_we_lw  = (state_q == StWb);
        pc_inc    = rf_we_add | mem_wr | rf_we_lw;
        retire    = pc_inc | pc_jump;
        led       = (state_q == StHalt);
    end

    always_comb begin
        pc_d      = pc_q;
        ir_d      = ir_q;
        rf_d      = rf_q;
        dmem_d    = dmem_q;
        mdr_d     = mdr_q;
        display_d = display_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        if (ir_load) begin
            ir_d = instruction;
        end
        if (rf_we_add) begin
            rf_d[fn]  = add_res[DATA_W-1:0];
            display_d = add_res[7:0];
            ovf_d     = ovf_q | add_res[DATA_W];
        end
        if (mem_rd) begin
            mdr_d = dmem_q[dmem_idx];
        end
        if (mem_wr) begin
            dmem_d[dmem_idx] = rf_q[rt];
        end
        if (rf_we_lw) begin
            rf_d[rt]  = mdr_q;
            display_d = mdr_q[7:0];
        end
        if (pc_inc) begin
            pc_d = pc_q + IMEM_AW'(1);
        end
        if (pc_jump) begin
            pc_d = pc_q + {{(IMEM_AW - 2){fn[1]}}, fn};
        end
        if (retire && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            pc_q      <= '0;
            ir_q      <= '0;
            mdr_q     <= '0;
            display_q <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            step_q    <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                rf_q[i] <= '0;
            end
            for (int unsigned i = 0; i < DMEM_DEPTH; i++) begin
                dmem_q[i] <= DATA_W'(i);
            end
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mdr_q     <= mdr_d;
            display_q <= display_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            step_q    <= step;
            rf_q      <= rf_d;
            dmem_q    <= dmem_d;
        end
    end

    assign read_address = pc_q;
    assign ovf          = ovf_q;
    assign instr_count  = cnt_q;

    hex7seg u_hex_hi (
        .value_i (display_q[7:4]),
        .seg_o   (seg_hi)
    );

    hex7seg u_hex_lo (
        .value_i (display_q[3:0]),
        .seg_o   (seg_lo)
    );

endmodule

// File: tb/tb_cpu8_core.sv
// Self-checking bench for cpu8_core: table of whole programs run to HALT,
// a per-retirement display scoreboard, and step-mode / reset-abort sequences.
module tb_cpu8_core;

    logic        clk50 = 1'b0;
    logic        reset = 1'b0;
    logic        run   = 1'b0;
    logic        step  = 1'b0;
    logic [7:0]  instruction;
    logic [7:0]  read_address;
    logic [6:0]  seg_hi, seg_lo;
    logic        led, ovf;
    logic [15:0] instr_count;

    logic [7:0]  imem [256];

    int checks = 0;
    int errors = 0;

    always #10 clk50 = ~clk50;

    assign instruction = imem[read_address];

    cpu8_core dut (
        .clk50        (clk50),
        .reset        (reset),
        .run          (run),
        .step         (step),
        .instruction  (instruction),
        .read_address (read_address),
        .seg_hi       (seg_hi),
        .seg_lo       (seg_lo),
        .led          (led),
        .ovf          (ovf),
        .instr_count  (instr_count)
    );

    typedef struct packed {
        logic [63:0] prog;       // byte i lands at imem[i]
        logic [7:0]  at254;
        logic [7:0]  exp_cycles; // reset release to led=1
        logic [7:0]  exp_pc;
        logic [15:0] exp_cnt;
        logic [7:0]  exp_disp;
        logic        exp_ovf;
        logic [1:0]  reg_idx;
        logic [7:0]  reg_val;
    } vec_t;

    typedef struct packed {
        logic [6:0] hi;
        logic [6:0] lo;
        logic       ov;
    } disp_t;

    vec_t  vecs [6];
    vec_t  sb_q [$];
    disp_t mon_q [$];
    logic  mon_en = 1'b0;
    logic [15:0] last_cnt = 16'd0;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk50);
        reset = 1'b1;
    endtask

    task automatic load(input logic [63:0] prog, input logic [7:0] b254);
        for (int a = 0; a < 256; a++) imem[a] = 8'hC0;
        for (int b = 0; b < 8; b++) imem[b] = prog[8*b +: 8];
        imem[254] = b254;
    endtask

    // Retirement scoreboard: every instr_count step pops one expected display/ovf
    always @(negedge clk50) begin
        if (mon_en && instr_count != last_cnt) begin
            if (mon_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon_extra: unexpected retirement, count %0d", instr_count);
            end else begin
                disp_t e;
                e = mon_q.pop_front();
                chk("mon_hi", seg_hi, e.hi);
                chk("mon_lo", seg_lo, e.lo);
                chk("mon_ovf", ovf, e.ov);
            end
        end
        last_cnt <= instr_count;
    end

    initial begin
        vec_t v;
        int   cyc;

        // {prog, at254, cycles, pc, count, display, ovf, reg, value}
        // lw r2,1(r0); lw r3,3(r0); add r1,r2,r3; j 0
        vecs[0] = '{64'hC0C0C0C0_C02D4F49, 8'hC0, 8'd12, 8'd3, 16'd3, 8'd4, 1'b0, 2'd1, 8'd4};
        // lw r1,3(r0); add r1,r1,r1 x7; j 0 (default fill)
        vecs[1] = '{64'h15151515_15151547, 8'hC0, 8'd20, 8'd8, 16'd8, 8'd128, 1'b1, 2'd1,
                    8'd128};
        // lw r3,3(r0); sw r3,1(r3); lw r0,1(r3); j +1; j 0  (lw sets r3=3 first)
        vecs[2] = '{64'hC0C0C0C0_C171BD4F, 8'hC0, 8'd15, 8'd4, 16'd4, 8'd3, 1'b0, 2'd0, 8'd3};
        // j -2 wraps to 254: lw r3,2(r0); 255: j 0
        vecs[3] = '{64'hC0C0C0C0_C0C0C0C2, 8'h4E, 8'd8, 8'd255, 16'd2, 8'd2, 1'b0, 2'd3, 8'd2};
        // j -1 wraps to 255: j 0
        vecs[4] = '{64'hC0C0C0C0_C0C0C0C3, 8'hC0, 8'd4, 8'd255, 16'd1, 8'd0, 1'b0, 2'd0, 8'd0};
        // r1=3,6,12; add r0,r1,r1 -> 24; lw r2,3(r0) reads dmem[27 mod 16] = 11
        vecs[5] = '{64'hC0C0C04B_14151547, 8'hC0, 8'd16, 8'd5, 16'd5, 8'd11, 1'b0, 2'd0, 8'd24};

        // Reset state
        load(vecs[0].prog, vecs[0].at254);
        run = 1'b1;
        repeat (2) @(negedge clk50);
        reset = 1'b1;
        #1;
        chk("rst_pc", read_address, 8'd0);
        chk("rst_led", led, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_hi", seg_hi, 7'b1000000);
        chk("rst_lo", seg_lo, 7'b1000000);
        chk("rst_cnt", instr_count, 16'd0);

        for (int i = 0; i < 6; i++) begin
            load(vecs[i].prog, vecs[i].at254);
            run = 1'b1;
            sb_q.push_back(vecs[i]);
            do_reset();
            if (i == 1) begin
                logic [7:0] val;
                logic [8:0] dbl;
                logic       o;
                val = 8'd3;
                o   = 1'b0;
                mon_q.push_back('{seg7(val[7:4]), seg7(val[3:0]), o});
                for (int k = 0; k < 7; k++) begin
                    dbl = {1'b0, val} + {1'b0, val};
                    o   = o | dbl[8];
                    val = dbl[7:0];
                    mon_q.push_back('{seg7(val[7:4]), seg7(val[3:0]), o});
                end
                mon_en = 1'b1;
            end
            cyc = 0;
            while (!led && cyc < 300) begin
                @(negedge clk50);
                cyc++;
            end
            mon_en = 1'b0;
            v = sb_q.pop_front();
            chk($sformatf("c%0d_cycles", i), cyc, v.exp_cycles);
            repeat (3) @(negedge clk50);
            chk($sformatf("c%0d_led", i), led, 1'b1);
            chk($sformatf("c%0d_pc", i), read_address, v.exp_pc);
            chk($sformatf("c%0d_cnt", i), instr_count, v.exp_cnt);
            chk($sformatf("c%0d_hi", i), seg_hi, seg7(v.exp_disp[7:4]));
            chk($sformatf("c%0d_lo", i), seg_lo, seg7(v.exp_disp[3:0]));
            chk($sformatf("c%0d_ovf", i), ovf, v.exp_ovf);
            chk($sformatf("c%0d_reg", i), dut.rf_q[v.reg_idx], v.reg_val);
        end
        chk("mon_left", mon_q.size(), 0);

        // Asynchronous reset from HALT, sampled between clock edges
        #3 reset = 1'b0;
        #1;
        chk("arst_led", led, 1'b0);
        chk("arst_pc", read_address, 8'd0);
        chk("arst_cnt", instr_count, 16'd0);
        chk("arst_lo", seg_lo, 7'b1000000);

        // Single-step mode
        load(64'hC0C0C0C0_C12D4F49, 8'hC0);
        run = 1'b0;
        do_reset();
        repeat (4) @(negedge clk50);
        chk("st_pc1", read_address, 8'd1);
        chk("st_cnt1", instr_count, 16'd1);
        repeat (20) @(negedge clk50);
        chk("st_idle_pc", read_address, 8'd1);
        chk("st_idle_cnt", instr_count, 16'd1);
        step = 1'b1;
        @(negedge clk50);
        step = 1'b0;
        repeat (10) @(negedge clk50);
        chk("st_pc2", read_address, 8'd2);
        chk("st_cnt2", instr_count, 16'd2);
        chk("st_lo2", seg_lo, seg7(4'd3));
        step = 1'b1;
        @(negedge clk50);
        step = 1'b0;
        @(negedge clk50);
        step = 1'b1;   // lands in EXEC of the add
        @(negedge clk50);
        step = 1'b0;
        repeat (10) @(negedge clk50);
        chk("st_pc3", read_address, 8'd3);
        chk("st_cnt3", instr_count, 16'd3);
        chk("st_lo3", seg_lo, seg7(4'd4));
        run = 1'b1;
        repeat (6) @(negedge clk50);
        chk("st_run_led", led, 1'b1);
        chk("st_run_pc", read_address, 8'd4);
        chk("st_run_cnt", instr_count, 16'd4);

        // Reset during the MEM cycle of lw r2,1(r0)
        load(64'hC0C0C0C0_C0C0C049, 8'hC0);
        run = 1'b1;
        do_reset();
        repeat (2) @(negedge clk50);
        #5 reset = 1'b0;
        #1;
        chk("ab_pc", read_address, 8'd0);
        chk("ab_cnt", instr_count, 16'd0);
        repeat (2) @(negedge clk50);
        chk("ab_r2", dut.rf_q[2], 8'd0);
        chk("ab_lo", seg_lo, 7'b1000000);
        reset = 1'b1;
        repeat (4) @(negedge clk50);
        chk("ab_rerun_r2", dut.rf_q[2], 8'd1);
        chk("ab_rerun_cnt", instr_count, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
